program_launcher: RTL

PROGRAM_LAUNCHER -- requirements
Module: program_launcher

---
 rtl/program_launcher_if.sv | 50 +++++
 rtl/program_launcher.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/program_launcher_if.sv
// ----------------------------------------------------------------------------
// program_launcher_if
//
// Purpose:
//   Host-side handshake bundle for program_launcher. The request channel
//   starts one program run. The response channel returns the result of that
//   run.
//
// Signals:
//   req_valid    host -> launcher   host requests one program run
//   req_ready    launcher -> host   launcher can accept a request (IDLE only)
//   rsp_valid    launcher -> host   result available (RESP only)
//   rsp_ready    host -> launcher   host accepts the result
//   rsp_ret      launcher -> host   captured program return value (32 bit)
//   rsp_cycles   launcher -> host   WAIT-cycle count of the run (32 bit)
//   rsp_timeout  launcher -> host   run was aborted by timeout
//
// Modports:
//   master  host side (drives req_valid and rsp_ready)
//   slave   launcher side (drives req_ready and the response fields)
// ----------------------------------------------------------------------------
interface program_launcher_if;
  logic        req_valid;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_ret;
  logic [31:0] rsp_cycles;
  logic        rsp_timeout;

  modport master (
    output req_valid,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_ret,
    input  rsp_cycles,
    input  rsp_timeout
  );

  modport slave (
    input  req_valid,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_ret,
    output rsp_cycles,
    output rsp_timeout
  );
endinterface

// File: rtl/program_launcher.sv
// ----------------------------------------------------------------------------
// program_launcher
//
// Purpose:
//   Runs a compiled hardware program once for each host request. An accepted
//   request produces a one-cycle prog_start pulse that restarts the program.
//   The launcher then waits for the program's sticky finish flag, captures the
//   return value and the number of WAIT cycles, and holds the result on the
//   response channel until the host takes it.
//
//   FSM: IDLE -> START (1 cycle) -> WAIT -> RESP -> IDLE
//
// Parameters:
//   MIN_CYCLES  minimum wait_cnt before prog_finish counts as completion.
//               This hides a finish flag that is still high from the
//               previous run.
//   TIMEOUT     WAIT-cycle budget before the run is aborted. It is only
//               used when LAUNCHER_TIMEOUT_EN is defined.
//
// Build option:
//   LAUNCHER_TIMEOUT_EN  When defined, a run that reaches wait_cnt == TIMEOUT
//                        without completing ends with rsp_timeout=1,
//                        rsp_ret=0 and rsp_cycles=TIMEOUT. When undefined,
//                        no timeout logic is built and rsp_timeout is
//                        constant 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   host         program_launcher_if.slave request/response channel
//   prog_start   one-cycle restart pulse to the program
//   prog_finish  program finish flag (sticky)
//   prog_ret     program return value, valid while prog_finish is high
// ----------------------------------------------------------------------------
module program_launcher #(
  parameter int unsigned MIN_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  program_launcher_if.slave        host,
  output logic                     prog_start,
  input  logic                     prog_finish,
  input  logic [31:0]              prog_ret
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] MIN_CNT     = 32'(MIN_CYCLES);
  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

  state_t      state_reg;
  logic        req_ready_reg;
  logic        rsp_valid_reg;
  logic        prog_start_reg;
  logic [31:0] rsp_ret_reg;
  logic [31:0] rsp_cycles_reg;
  logic [31:0] wait_cnt_reg;
  logic [31:0] wait_cnt_next;
  logic        completion;

  // The counter sticks at all-ones. A very long run then reports a
  // saturated count instead of wrapping to a small one.
  assign wait_cnt_next = (wait_cnt_reg == 32'hFFFF_FFFF) ? wait_cnt_reg
                                                         : wait_cnt_reg + 32'd1;

  // prog_finish is ignored for the first MIN_CYCLES samples of a run. Until
  // then the flag may still be the stale one from the previous run.
  assign completion = prog_finish && (wait_cnt_reg >= MIN_CNT);

`ifdef LAUNCHER_TIMEOUT_EN
  logic rsp_timeout_reg;
  logic timed_out;

  assign timed_out        = (wait_cnt_reg >= TIMEOUT_CNT);
  assign host.rsp_timeout = rsp_timeout_reg;
`else
  // Without the timeout feature, TIMEOUT only feeds this discarded
  // reduction, so the parameter stays referenced.
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CNT;
  assign host.rsp_timeout   = 1'b0;
`endif

  assign host.req_ready  = req_ready_reg;
  assign host.rsp_valid  = rsp_valid_reg;
  assign host.rsp_ret    = rsp_ret_reg;
  assign host.rsp_cycles = rsp_cycles_reg;
  assign prog_start      = prog_start_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      prog_start_reg  <= 1'b0;
      rsp_ret_reg     <= 32'd0;
      rsp_cycles_reg  <= 32'd0;
      wait_cnt_reg    <= 32'd0;
`ifdef LAUNCHER_TIMEOUT_EN
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // req_ready is registered. In the first cycle after reset it is
          // still low, and from the next edge on it is high for as long as
          // the launcher stays idle.
          req_ready_reg <= 1'b1;
          if (host.req_valid && req_ready_reg) begin
            req_ready_reg  <= 1'b0;
            prog_start_reg <= 1'b1;
            state_reg      <= START;
          end
        end

        START: begin
          prog_start_reg <= 1'b0;
          wait_cnt_reg   <= 32'd0;
          state_reg      <= WAIT;
        end

        WAIT: begin
          // Completion is tested first, so it wins when completion and
          // timeout qualify on the same sample.
          if (completion) begin
            rsp_ret_reg     <= prog_ret;
            rsp_cycles_reg  <= wait_cnt_reg;
`ifdef LAUNCHER_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
`ifdef LAUNCHER_TIMEOUT_EN
          end else if (timed_out) begin
            rsp_ret_reg     <= 32'd0;
            rsp_cycles_reg  <= TIMEOUT_CNT;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
`endif
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end

        RESP: begin
          // The response registers are not written here, so the result
          // stays stable while the host stalls.
          if (host.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
